// File: rtl/uart_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter_if
// Purpose  : Byte handshake between a data source and uart_transmitter.
// Signals  : tx_data  [DATA_BITS] byte to send        (master -> slave)
//            tx_valid             tx_data is valid     (master -> slave)
//            tx_ready             slave accepts a byte (slave  -> master)
// Modports : master (byte source), slave (transmitter)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_transmitter_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter
// Purpose  : Serialises one byte per valid/ready handshake onto a UART line:
//            start bit (0), DATA_BITS data bits LSB first, STOP_BITS stop
//            bits (1). Each bit lasts max(i_dvsr,1) clk cycles, latched at
//            acceptance.
// Ports    : clk           system clock, rising edge
//            rst           asynchronous, active-low reset
//            i_dvsr        clk cycles per bit (0 treated as 1)
//            tx_if         slave side of byte handshake (data/valid/ready)
//            o_serial_out  UART line, idle high
//            o_busy        frame in progress
//            o_tx_done     1-cycle pulse when the last stop bit completes
// Revision : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DVSR_W    = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [DVSR_W-1:0] i_dvsr,
  uart_transmitter_if.slave      tx_if,
  output logic                   o_serial_out,
  output logic                   o_busy,
  output logic                   o_tx_done
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  localparam logic [3:0] c_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] c_LAST_STOP = 4'(STOP_BITS - 1);

  logic [1:0]           r_state, w_state_nxt;
  logic [DVSR_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DVSR_W-1:0]    r_period, w_period_nxt;
  logic [3:0]           r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_serial, w_serial_nxt;
  logic                 r_ready, w_ready_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;

  logic                 w_accept;
  logic                 w_bit_end;
  logic [DVSR_W-1:0]    w_period_in;

  assign w_accept    = tx_if.tx_valid && r_ready;
  // Compare against the latched period so a mid-frame dvsr change is inert.
  assign w_bit_end   = (r_cnt == (r_period - DVSR_W'(1)));
  assign w_period_in = (i_dvsr == '0) ? DVSR_W'(1) : i_dvsr;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_serial  <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_period  <= w_period_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_serial  <= w_serial_nxt;
      r_ready   <= w_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_nxt = c_START;
      c_START: if (w_bit_end) w_state_nxt = c_DATA;
      c_DATA:  if (w_bit_end && (r_bit_cnt == c_LAST_DATA)) w_state_nxt = c_STOP;
      c_STOP:  if (w_bit_end && (r_bit_cnt == c_LAST_STOP)) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    w_cnt_nxt     = w_bit_end ? '0 : r_cnt + DVSR_W'(1);
    w_period_nxt  = r_period;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_serial_nxt  = r_serial;
    w_ready_nxt   = r_ready;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_shift_nxt   = tx_if.tx_data;
          w_period_nxt  = w_period_in;
          w_bit_cnt_nxt = '0;
          w_serial_nxt  = 1'b0;
          w_ready_nxt   = 1'b0;
          w_busy_nxt    = 1'b1;
        end
      end
      c_START: begin
        if (w_bit_end) begin
          w_serial_nxt  = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = '0;
        end
      end
      c_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == c_LAST_DATA) begin
            w_serial_nxt  = 1'b1;
            w_bit_cnt_nxt = '0;
          end else begin
            w_serial_nxt  = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      c_STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt == c_LAST_STOP) begin
            w_bit_cnt_nxt = '0;
            w_cnt_nxt     = '0;
            w_ready_nxt   = 1'b1;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_cnt_nxt    = '0;
        w_serial_nxt = 1'b1;
        w_ready_nxt  = 1'b1;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  assign tx_if.tx_ready = r_ready;
  assign o_serial_out   = r_serial;
  assign o_busy         = r_busy;
  assign o_tx_done      = r_done;

endmodule
`default_nettype wire
